// File: rtl/ad9228_tx_gearbox.sv
// AD9228 transmit gearbox: packs DATA_WIDTH samples into an MSB-first
// OUT_WIDTH byte stream with a per-byte sample-start marker (fco_out).
module ad9228_tx_gearbox #(
  parameter int DATA_WIDTH = 12,
  parameter int OUT_WIDTH  = 8,
  localparam int BUF_WIDTH = 2 * DATA_WIDTH,
  localparam int LW        = $clog2(BUF_WIDTH + 1)
) (
  input  logic                  data_in_clk,
  input  logic                  rstn,
  input  logic                  sync_clr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [OUT_WIDTH-1:0]  data_out,
  output logic                  data_valid_out,
  output logic [OUT_WIDTH-1:0]  fco_out,
  output logic [LW-1:0]         level
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [LW-1:0] OW_L    = LW'(OUT_WIDTH);
  localparam logic [LW-1:0] DW_L    = LW'(DATA_WIDTH);
  localparam logic [LW-1:0] RDY_MAX = LW'(BUF_WIDTH - DATA_WIDTH);

  logic [BUF_WIDTH-1:0] sr_q, sr_d;
  logic [BUF_WIDTH-1:0] mk_q, mk_d;
  logic [BUF_WIDTH-1:0] sr_sh, mk_sh, keep_m;
  logic [LW-1:0]        lvl_q, lvl_d, ld;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic [OUT_WIDTH-1:0] fco_q, fco_d;
  logic                 dv_q, dv_d;
  logic [1:0]           st_q, st_d;
  logic                 emit, accept;

  always_comb begin
    emit   = (st_q == S_OUT);
    ld     = emit ? lvl_q - OW_L : lvl_q;
    data_in_ready = (ld <= RDY_MAX);
    accept = data_in_valid && data_in_ready;
    sr_sh  = sr_q >> (lvl_q - OW_L);
    mk_sh  = mk_q >> (lvl_q - OW_L);
    keep_m = ~({BUF_WIDTH{1'b1}} << ld);

    dout_d = dout_q;
    fco_d  = fco_q;
    dv_d   = 1'b0;
    if (emit) begin
      dout_d = sr_sh[OUT_WIDTH-1:0];
      fco_d  = mk_sh[OUT_WIDTH-1:0];
      dv_d   = 1'b1;
    end

    // Drained bits are masked off so nothing above the new level survives
    sr_d  = sr_q & keep_m;
    mk_d  = mk_q & keep_m;
    lvl_d = ld;
    if (accept) begin
      sr_d  = {sr_d[BUF_WIDTH-DATA_WIDTH-1:0], data_in};
      mk_d  = {mk_d[BUF_WIDTH-DATA_WIDTH-1:0],
               1'b1, {(DATA_WIDTH-1){1'b0}}};
      lvl_d = ld + DW_L;
    end

    st_d = S_IDLE;
    unique case (1'b1)
      (lvl_d == '0):                  st_d = S_IDLE;
      (lvl_d != '0 && lvl_d < OW_L):  st_d = S_ACC;
      (lvl_d >= OW_L):                st_d = S_OUT;
      default:                        st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge data_in_clk or negedge rstn) begin
    if (!rstn) begin
      sr_q   <= '0;
      mk_q   <= '0;
      lvl_q  <= '0;
      st_q   <= S_IDLE;
      dout_q <= '0;
      fco_q  <= '0;
      dv_q   <= 1'b0;
    end else if (sync_clr) begin
      sr_q   <= '0;
      mk_q   <= '0;
      lvl_q  <= '0;
      st_q   <= S_IDLE;
      dout_q <= '0;
      fco_q  <= '0;
      dv_q   <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      mk_q   <= mk_d;
      lvl_q  <= lvl_d;
      st_q   <= st_d;
      dout_q <= dout_d;
      fco_q  <= fco_d;
      dv_q   <= dv_d;
    end
  end

  assign data_out       = dout_q;
  assign fco_out        = fco_q;
  assign data_valid_out = dv_q;
  assign level          = lvl_q;

endmodule
